// File: rtl/fetch_queue_if.sv
// Single-port synchronous instruction RAM link: request on en_i_a/addr_i_a,
// read data appears on data_o_a one cycle later.
interface ram_interface #(
   parameter int XLEN = 32
) ();
   logic            en_i_a;
   logic [XLEN-1:0] addr_i_a;
   logic [XLEN-1:0] data_o_a;

   modport master (output en_i_a, output addr_i_a, input data_o_a);
   modport slave  (input en_i_a, input addr_i_a, output data_o_a);
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential word fetches to a 1-cycle RAM and
// buffers responses in a small queue, with redirect flush and back-pressure.
module fetch_queue #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              QUEUE_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            ready_i,
   output logic            valid_o,
   output logic [XLEN-1:0] instruction_o,
   output logic [XLEN-1:0] pc_o,
   ram_interface.master    ram_if
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 2;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   occupancy;
   logic            push, pop, issue;

   logic [XLEN-1:0] instr_mem_q [QUEUE_DEPTH];
   logic [XLEN-1:0] pc_mem_q    [QUEUE_DEPTH];

   always_comb begin
      valid_o    = (count_q != '0) && !redirect_valid_i;
      pop        = valid_o && ready_i;
      push       = inflight_q && !redirect_valid_i;
      // Slots already promised (queued + in flight) after this cycle's pop.
      occupancy  = count_q + CW'(inflight_q) - CW'(pop);
      issue      = !rst_i && !redirect_valid_i && (occupancy < CW'(QUEUE_DEPTH));

      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;

      if (redirect_valid_i) begin
         fetch_pc_d = redirect_pc_i;
         inflight_d = 1'b0;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            req_pc_d   = fetch_pc_q;
         end
         inflight_d = issue;
         count_d    = count_q + CW'(push) - CW'(pop);
         head_d     = head_q + PW'(pop);
         tail_d     = tail_q + PW'(push);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Queue storage carries no reset; contents are only read while count_q != 0.
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_mem_q[tail_q] <= ram_if.data_o_a;
         pc_mem_q[tail_q]    <= req_pc_q;
      end
   end

   assign ram_if.en_i_a   = issue;
   assign ram_if.addr_i_a = fetch_pc_q;
   assign instruction_o   = instr_mem_q[head_q];
   assign pc_o            = pc_mem_q[head_q];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: depth-2 and depth-4 instances share stimulus,
// each backed by a RAM model that returns (addr ^ DKEY) one cycle after request.
module tb_fetch_queue;
   localparam int          XLEN = 32;
   localparam logic [31:0] DKEY = 32'hA5A5_0000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            redirect_valid = 1'b0;
   logic [XLEN-1:0] redirect_pc = '0;
   logic            ready = 1'b1;

   logic            v2, v4;
   logic [XLEN-1:0] i2, i4, p2, p4;

   int tests_run    = 0;
   int tests_failed = 0;

   ram_interface #(.XLEN(XLEN)) ram2 ();
   ram_interface #(.XLEN(XLEN)) ram4 ();

   fetch_queue #(.XLEN(XLEN), .RESET_PC(32'h0), .QUEUE_DEPTH(2)) u_dut2 (
      .clk_i           (clk),
      .rst_i           (rst),
      .redirect_valid_i(redirect_valid),
      .redirect_pc_i   (redirect_pc),
      .ready_i         (ready),
      .valid_o         (v2),
      .instruction_o   (i2),
      .pc_o            (p2),
      .ram_if          (ram2)
   );

   fetch_queue #(.XLEN(XLEN), .RESET_PC(32'h0), .QUEUE_DEPTH(4)) u_dut4 (
      .clk_i           (clk),
      .rst_i           (rst),
      .redirect_valid_i(redirect_valid),
      .redirect_pc_i   (redirect_pc),
      .ready_i         (ready),
      .valid_o         (v4),
      .instruction_o   (i4),
      .pc_o            (p4),
      .ram_if          (ram4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram2.en_i_a) ram2.data_o_a <= ram2.addr_i_a ^ DKEY;
      if (ram4.en_i_a) ram4.data_o_a <= ram4.addr_i_a ^ DKEY;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %h", tag, got);
      end
   endtask

   // Apply inputs just after the falling edge, then let combinational outputs settle.
   task automatic tick(input logic rst_v, input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clk);
      rst            = rst_v;
      redirect_valid = rv;
      redirect_pc    = rpc;
      ready          = rdy;
      #1;
   endtask

   initial begin
      // Reset state and streaming start
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      check("rst_v2",  32'(v2), 32'h0);
      check("rst_en2", 32'(ram2.en_i_a), 32'h0);
      check("rst_v4",  32'(v4), 32'h0);
      check("rst_en4", 32'(ram4.en_i_a), 32'h0);
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("c0_en2",   32'(ram2.en_i_a), 32'h1);
      check("c0_addr2", ram2.addr_i_a, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("c1_v2",    32'(v2), 32'h0);
      check("c1_addr2", ram2.addr_i_a, 32'h4);
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1);
         check("str_v2", 32'(v2), 32'h1);
         check("str_p2", p2, 32'(4 * k));
         check("str_i2", i2, 32'(4 * k) ^ DKEY);
         check("str_p4", p4, 32'(4 * k));
      end

      // Back-pressure: ready low for 5 cycles from first valid
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("st2_en2",   32'(ram2.en_i_a), 32'h0);
      check("st2_en4",   32'(ram4.en_i_a), 32'h1);
      check("st2_addr4", ram4.addr_i_a, 32'h8);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("st3_en4",   32'(ram4.en_i_a), 32'h1);
      check("st3_addr4", ram4.addr_i_a, 32'hC);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("st4_en4",   32'(ram4.en_i_a), 32'h0);
      check("st4_en2",   32'(ram2.en_i_a), 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("hold_v2", 32'(v2), 32'h1);
      check("hold_p2", p2, 32'h0);
      check("hold_i2", i2, DKEY);
      check("hold_v4", 32'(v4), 32'h1);
      check("hold_i4", i4, DKEY);
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1);
         if (k == 0) begin
            check("rel_en2",   32'(ram2.en_i_a), 32'h1);
            check("rel_addr2", ram2.addr_i_a, 32'h8);
         end
         check("rel_v2", 32'(v2), 32'h1);
         check("rel_p2", p2, 32'(4 * k));
         check("rel_p4", p4, 32'(4 * k));
      end

      // Redirect with one queued and one in flight
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b1, 32'h100, 1'b1);
      check("rd_v2",  32'(v2), 32'h0);
      check("rd_en2", 32'(ram2.en_i_a), 32'h0);
      check("rd_v4",  32'(v4), 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd1_en2",   32'(ram2.en_i_a), 32'h1);
      check("rd1_addr2", ram2.addr_i_a, 32'h100);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd2_v2", 32'(v2), 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd3_p2", p2, 32'h100);
      check("rd3_i2", i2, 32'h100 ^ DKEY);
      check("rd3_p4", p4, 32'h100);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd4_p2", p2, 32'h104);

      // Back-to-back redirects: last target wins
      tick(1'b0, 1'b1, 32'h200, 1'b1);
      tick(1'b0, 1'b1, 32'h300, 1'b1);
      check("bb_v2", 32'(v2), 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("bb_addr2", ram2.addr_i_a, 32'h300);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("bb2_v2", 32'(v2), 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("bb_p2", p2, 32'h300);
      check("bb_p4", p4, 32'h300);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("bb_p2n", p2, 32'h304);

      // Address wrap past 2^32
      tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("wr_p2a", p2, 32'hFFFF_FFF8);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("wr_p2b", p2, 32'hFFFF_FFFC);
      check("wr_p4b", p4, 32'hFFFF_FFFC);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("wr_p2c", p2, 32'h0);
      check("wr_i2c", i2, DKEY);

      // Misaligned target is used unchanged
      tick(1'b0, 1'b1, 32'h102, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("mis_p2a", p2, 32'h102);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("mis_p2b", p2, 32'h106);

      // Asynchronous reset mid-stream
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_pre_v4", 32'(v4), 32'h1);
      rst = 1'b1;
      #1;
      check("ar_v4",  32'(v4), 32'h0);
      check("ar_v2",  32'(v2), 32'h0);
      check("ar_en4", 32'(ram4.en_i_a), 32'h0);
      tick(1'b1, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_c0_addr4", ram4.addr_i_a, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_c1_v4", 32'(v4), 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_c2_p4", p4, 32'h0);
      check("ar_c2_p2", p2, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_c3_p4", p4, 32'h4);
      check("ar_c3_i4", i4, 32'h4 ^ DKEY);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: width of PC, address and instruction.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter QUEUE_DEPTH, default 2: instruction queue entries; power of two, at least 2.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 redirect_valid_i  input  1  branch/jump redirect request.
REQ-007 redirect_pc_i  input  XLEN  redirect target address.
REQ-008 ready_i  input  1  downstream accepts the head instruction.
REQ-009 valid_o  output  1  queue head holds a valid instruction.
REQ-010 instruction_o  output  XLEN  head instruction word.
REQ-011 pc_o  output  XLEN  address of head instruction.
REQ-012 ram_if  ram_interface.master  --  en_i_a request enable, addr_i_a byte address, data_o_a read data one cycle after request.

Function
REQ-013 Internal fetch_pc register holds the next request address; it is XLEN wide and wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
REQ-014 Issue condition: request issues when !redirect_valid_i and (count + inflight - pop) < QUEUE_DEPTH, where count = queued entries, inflight = outstanding request (0/1), pop = valid_o && ready_i.
REQ-015 Issuing cycle: en_i_a=1, addr_i_a=fetch_pc; fetch_pc advances by 4; inflight set; captured request PC stored for the response.
REQ-016 Non-issuing cycle: en_i_a=0; fetch_pc unchanged.
REQ-017 Response: in the cycle after issue, data_o_a and stored PC are written to the queue tail at the end of that cycle; inflight clears unless a new request issues.
REQ-018 Latency: request in cycle N -> entry visible on valid_o/instruction_o/pc_o in cycle N+2.
REQ-019 Pop on valid_o && ready_i; the head advances at the end of the cycle; push and pop may occur in the same cycle, leaving count unchanged.
REQ-020 Throughput: with ready_i held 1, one instruction is delivered per cycle in steady state, for any QUEUE_DEPTH >= 2.
REQ-021 Hold: while valid_o=1 and ready_i=0, valid_o, instruction_o and pc_o remain stable.
REQ-022 Full: count never exceeds QUEUE_DEPTH; no response ever arrives without a free slot, guaranteed by REQ-014.
REQ-023 Empty: valid_o=0 when count=0; instruction_o and pc_o are don't-care.
REQ-024 Redirect cycle: fetch_pc <= redirect_pc_i; queue is flushed (count=0); any in-flight response is discarded and not written; no request issues; valid_o is forced 0 so no pop occurs.
REQ-025 After redirect in cycle R: request at redirect_pc_i in R+1; instruction visible in R+3.
REQ-026 Back-to-back redirects: the last asserted target wins; each redirect re-applies REQ-024.
REQ-027 Misaligned redirect_pc_i (bits [1:0] != 0) is used as-is; alignment checking is not performed in this block.

Reset
REQ-028 While rst_i=1: fetch_pc=RESET_PC, count=0, inflight=0, valid_o=0, en_i_a=0; queue contents are don't-care.
REQ-029 Reset asserted mid-operation takes effect immediately, without waiting for a clock edge; a response pending at that time is discarded.
REQ-030 First clock edge after rst_i deasserts: request at RESET_PC issues in that cycle (cycle 0); valid_o=1 with pc_o=RESET_PC in cycle 2.

Verification
REQ-031 Reset release, ready_i=1, RAM returns addr as data -> pc_o/instruction_o = 0,4,8,C on consecutive cycles starting at cycle 2.
REQ-032 ready_i=0 for 5 cycles after first valid -> en_i_a stops after queue+inflight reach QUEUE_DEPTH; outputs stable at pc 0; ready_i=1 then yields 0,4,8,... with no gaps or duplicates.
REQ-033 Redirect to 0x100 while one entry is queued and one in flight -> both dropped; next valid_o shows pc_o=0x100 two cycles after its request.
REQ-034 Redirect to 0x200 then 0x300 on consecutive cycles -> first delivered pc_o=0x300; 0x200 is never delivered.
REQ-035 Redirect to 0xFFFF_FFF8 with ready_i=1 -> delivered pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst_i asserted asynchronously mid-stream with QUEUE_DEPTH=4 -> valid_o=0 immediately; after release, the sequence restarts at RESET_PC.
